// File: rtl/mult_datapath.sv
// -----------------------------------------------------------------------------
// mult_datapath
//
// Sequential signed shift-add multiplier. Operands are converted to magnitudes
// at load time, multiplied unsigned one bit per enabled cycle, and the product
// is negated on the way out if the operand signs differed.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset (highest priority)
//   l_s           load strobe: samples operands and starts an operation (IDLE only)
//   enable        step strobe: one shift-add step per high cycle in RUN
//   multiplicand  signed operand A, DW bits
//   multiplier    signed operand B, DW bits
//   product       signed result A*B, 2*DW bits, registered, held between results
//   busy          high while in RUN or DONE
//   done          one-cycle pulse when product is updated
// -----------------------------------------------------------------------------
module mult_datapath #(
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l_s,
  input  logic              enable,
  input  logic [DW-1:0]     multiplicand,
  input  logic [DW-1:0]     multiplier,
  output logic [2*DW-1:0]   product,
  output logic              busy,
  output logic              done
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   mcand_r;
  logic [2*DW:0]   p_r;
  logic            neg_r;
  logic [CW-1:0]   cnt;

  logic [DW-1:0]   mag_a, mag_b;
  logic [DW:0]     add_hi;
  logic [2*DW:0]   p_step;
  logic            last_step;

  // Two's-complement magnitude. The most negative value maps onto itself,
  // which read as unsigned is exactly 2^(DW-1), so no extra bit is needed.
  assign mag_a = multiplicand[DW-1] ? -multiplicand : multiplicand;
  assign mag_b = multiplier[DW-1]   ? -multiplier   : multiplier;

  assign last_step = (cnt == CW'(DW-1));

  // One shift-add step: conditional (DW+1)-bit add into the upper half,
  // carry kept, followed by a logical right shift of the whole register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    add_hi = p_r[2*DW:DW] + {1'b0, mcand_r};
    p_step = p_r;
    if (p_r[0]) begin
      p_step = {add_hi, p_r[DW-1:0]};
    end
    p_step = p_step >> 1;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (l_s) state_nx = RUN;
      RUN:     if (enable && last_step) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    // NOTE: everything here, datapath included, is cleared by reset so that
    // a reset mid-operation leaves no stale partial result behind.
    if (rst) begin
      state   <= IDLE;
      mcand_r <= '0;
      p_r     <= '0;
      neg_r   <= 1'b0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (l_s) begin
            mcand_r <= mag_a;
            p_r     <= {{(DW+1){1'b0}}, mag_b};
            neg_r   <= multiplicand[DW-1] ^ multiplier[DW-1];
            cnt     <= '0;
          end
        end
        RUN: begin
          if (enable) begin
            p_r <= p_step;
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // A zero magnitude negates to zero, so neg_r needs no special case.
          product <= neg_r ? -p_r[2*DW-1:0] : p_r[2*DW-1:0];
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // busy follows the state, so it drops in the same cycle done rises.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_datapath.sv
// -----------------------------------------------------------------------------
// tb_mult_datapath
//
// Self-checking bench for mult_datapath (DW = 16). Expected products come from
// native signed multiplication; expected latency comes from counting enabled
// cycles after the load: the result appears one edge after the DW-th enabled
// RUN edge.
// -----------------------------------------------------------------------------
module tb_mult_datapath;

  localparam int DW    = 16;
  localparam int LIMIT = 8 * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            l_s;
  logic            enable;
  logic [DW-1:0]   multiplicand;
  logic [DW-1:0]   multiplier;
  logic [2*DW-1:0] product;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_pass   = 0;

  mult_datapath #(.DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .l_s          (l_s),
    .enable       (enable),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [2*DW-1:0] model_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    return p[2*DW-1:0];
  endfunction

  // Runs one operation starting at a negedge. mode: 0 enable always high,
  // 1 enable low on odd RUN edges / high on even ones, 2 random enable.
  // lat is the edge index (load edge = 0) after which done was seen, -1 on
  // timeout. err counts busy/product-hold violations while the operation ran.
  task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input int mode, input bit junk,
                       output int lat, output int exp_lat,
                       output logic [2*DW-1:0] prod, output int err);
    logic [2*DW-1:0] hold;
    int steps;
    hold    = product;
    err     = 0;
    lat     = -1;
    exp_lat = -1;
    steps   = 0;
    prod    = 'x;
    multiplicand = a;
    multiplier   = b;
    l_s    = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    l_s = 1'b0;
    if (busy !== 1'b1) err++;
    for (int k = 1; k <= LIMIT; k++) begin
      case (mode)
        0:       enable = 1'b1;
        1:       enable = (k % 2 == 0);
        default: enable = ($urandom_range(0, 3) != 0);
      endcase
      if (junk) begin
        l_s          = 1'($urandom_range(0, 1));
        multiplicand = DW'($urandom);
        multiplier   = DW'($urandom);
      end
      @(posedge clk);
      if (enable && steps < DW) begin
        steps++;
        if (steps == DW) exp_lat = k + 1;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        lat  = k;
        prod = product;
        if (busy !== 1'b0) err++;
        break;
      end
      if (busy !== 1'b1 || product !== hold) err++;
    end
    l_s    = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b1;
    l_s = 1'b1;
    enable = 1'b1;
    multiplicand = 16'd3;
    multiplier   = 16'd4;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    l_s = 1'b0;
    n_checks++;
    if (product !== '0) $display("FAIL reset_product got %h want 0", product);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      enable = (i % 2 == 0);
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) bad++;
    end
    enable = 1'b0;
    n_checks++;
    if (bad !== 0) $display("FAIL idle_enable got %0d changed cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_basic;
    int lat, exp_lat, err;
    logic [2*DW-1:0] prod;
    do_op(16'd7, 16'd6, 0, 1'b0, lat, exp_lat, prod, err);
    n_checks++;
    if (lat !== DW + 1) $display("FAIL basic_latency got done after edge %0d want %0d", lat, DW + 1);
    else n_pass++;
    n_checks++;
    if (prod !== 32'd42) $display("FAIL basic_product got %0d want 42", prod);
    else n_pass++;
    n_checks++;
    if (err !== 0) $display("FAIL basic_busy_hold got %0d violations want 0", err);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || product !== 32'd42)
      $display("FAIL basic_single_pulse got done=%b product=%0d want 0 42", done, product);
    else n_pass++;
  endtask

  task automatic test_signs;
    logic [DW-1:0]   ta [5];
    logic [DW-1:0]   tb [5];
    logic [2*DW-1:0] tw [5];
    int lat, exp_lat, err;
    logic [2*DW-1:0] prod;
    ta[0] = 16'hFFFD; tb[0] = 16'd5;    tw[0] = 32'hFFFFFFF1;
    ta[1] = 16'h8000; tb[1] = 16'h8000; tw[1] = 32'h40000000;
    ta[2] = 16'h7FFF; tb[2] = 16'h8000; tw[2] = 32'hC0008000;
    ta[3] = 16'd0;    tb[3] = 16'hFFFB; tw[3] = 32'd0;
    ta[4] = 16'h8000; tb[4] = 16'd1;    tw[4] = 32'hFFFF8000;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], 0, 1'b0, lat, exp_lat, prod, err);
      n_checks++;
      if (prod !== tw[i] || lat !== DW + 1)
        $display("FAIL signs_%0d got product=%h lat=%0d want %h lat=%0d", i, prod, lat, tw[i], DW + 1);
      else n_pass++;
    end
  endtask

  task automatic test_stall;
    int lat, exp_lat, err;
    logic [2*DW-1:0] prod;
    do_op(16'd100, -16'sd100, 1, 1'b1, lat, exp_lat, prod, err);
    n_checks++;
    if (lat !== 2 * DW + 1) $display("FAIL stall_latency got %0d want %0d", lat, 2 * DW + 1);
    else n_pass++;
    n_checks++;
    if (prod !== -32'sd10000) $display("FAIL stall_product got %h want %h", prod, -32'sd10000);
    else n_pass++;
    n_checks++;
    if (err !== 0) $display("FAIL stall_busy_hold got %0d violations want 0", err);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int lat, exp_lat, err, bad;
    logic [2*DW-1:0] prod;
    multiplicand = 16'd9;
    multiplier   = 16'd9;
    l_s    = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    l_s = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0)
      $display("FAIL reset_mid got busy=%b done=%b product=%h want 0 0 0", busy, done, product);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 2 * DW; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    enable = 1'b0;
    n_checks++;
    if (bad !== 0) $display("FAIL reset_mid_no_done got %0d bad cycles want 0", bad);
    else n_pass++;
    do_op(16'd9, 16'd9, 0, 1'b0, lat, exp_lat, prod, err);
    n_checks++;
    if (prod !== 32'd81 || lat !== DW + 1)
      $display("FAIL reset_mid_reload got product=%0d lat=%0d want 81 lat=%0d", prod, lat, DW + 1);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat, exp_lat, err;
    logic [2*DW-1:0] prod;
    do_op(16'd5, -16'sd7, 0, 1'b0, lat, exp_lat, prod, err);
    n_checks++;
    if (prod !== -32'sd35) $display("FAIL b2b_first got %h want %h", prod, -32'sd35);
    else n_pass++;
    // Issued in the same cycle done is high.
    do_op(16'hFFFF, 16'hFFFF, 0, 1'b0, lat, exp_lat, prod, err);
    n_checks++;
    if (lat !== DW + 1) $display("FAIL b2b_latency got %0d want %0d", lat, DW + 1);
    else n_pass++;
    n_checks++;
    if (prod !== 32'd1) $display("FAIL b2b_product got %h want 1", prod);
    else n_pass++;
    n_checks++;
    if (err !== 0) $display("FAIL b2b_hold got %0d violations want 0", err);
    else n_pass++;
  endtask

  task automatic test_random;
    int lat, exp_lat, err;
    logic [2*DW-1:0] prod, want;
    logic [DW-1:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = DW'($urandom);
      b = DW'($urandom);
      if (i % 5 == 0) a = 16'h8000;
      if (i % 7 == 3) b = 16'h7FFF;
      want = model_mul(a, b);
      do_op(a, b, 2, 1'b1, lat, exp_lat, prod, err);
      n_checks++;
      if (prod !== want || lat !== exp_lat || err !== 0)
        $display("FAIL random_%0d a=%h b=%h got product=%h lat=%0d err=%0d want %h lat=%0d err=0",
                 i, a, b, prod, lat, err, want, exp_lat);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0;
    l_s = 1'b0;
    enable = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_signs;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
